// File: rtl/priority_resolver_pkg.sv
// Shared TCAM search-path types and helpers: resolver state encoding,
// priority width rule and the priority-compare convention.
package tcam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RESULT  = 2'd3
  } res_state_t;

  localparam int unsigned PRIO_MAXW = 32;
  localparam int unsigned DRAIN_CW  = 4;

  // Priority fields are as wide as the rule ID they qualify.
  function automatic int unsigned prio_width(input int unsigned idwid);
    return idwid;
  endfunction

  // Lower numeric priority wins; an equal priority leaves the incumbent in place.
  function automatic logic prio_wins(input logic [PRIO_MAXW-1:0] cand,
                                     input logic [PRIO_MAXW-1:0] best);
    return cand < best;
  endfunction

endpackage

// File: rtl/priority_resolver_if.sv
// Confirm-side inputs and result-side handshake of the priority resolver.
interface priority_resolver_if
  import tcam_pkg::*;
#(
  parameter int unsigned IDWID  = 2,
  parameter int unsigned CNTWID = 4
);
  localparam int unsigned PRIOWID = prio_width(IDWID);

  logic [IDWID-1:0]   i_confirm_ruleid;
  logic [PRIOWID-1:0] i_confirm_priority;
  logic               i_confirm_valid;
  logic               i_confirm_complete;
  logic               i_result_ready;
  logic               o_result_valid;
  logic               o_result_hit;
  logic [IDWID-1:0]   o_result_ruleid;
  logic [PRIOWID-1:0] o_result_priority;
  logic [CNTWID-1:0]  o_match_count;
  logic               o_busy;
  logic               o_overrun;

  modport master (
    input  i_confirm_ruleid, i_confirm_priority, i_confirm_valid,
    input  i_confirm_complete, i_result_ready,
    output o_result_valid, o_result_hit, o_result_ruleid, o_result_priority,
    output o_match_count, o_busy, o_overrun
  );

  modport slave (
    output i_confirm_ruleid, i_confirm_priority, i_confirm_valid,
    output i_confirm_complete, i_result_ready,
    input  o_result_valid, o_result_hit, o_result_ruleid, o_result_priority,
    input  o_match_count, o_busy, o_overrun
  );

endinterface

// File: rtl/priority_resolver_edge.sv
// Rise/fall pulse generator for a level input; the delayed copy resets low.
module level_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_d;
  assign o_fall = ~i_level & r_level_d;

endmodule

// File: rtl/priority_resolver.sv
// Keeps the best confirmed rule over one search window and presents it as a
// held result with a valid/ready handshake, plus hit count and overrun pulse.
module priority_resolver
  import tcam_pkg::*;
#(
  parameter int unsigned IDWID        = 2,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNTWID       = 4
) (
  input  logic                clk,
  input  logic                reset,
  priority_resolver_if.master bus
);

  localparam int unsigned PRIOWID = prio_width(IDWID);
  localparam logic [DRAIN_CW-1:0] DRAIN_LOAD = DRAIN_CW'(DRAIN_CYCLES - 1);

  res_state_t r_state;
  res_state_t w_state_nxt;

  logic                w_rise;
  logic                w_fall;
  logic                w_clear;
  logic                w_accept;
  logic                w_load_drain;
  logic                w_drain_dec;
  logic                w_overrun;
  logic                w_replace;

  logic [DRAIN_CW-1:0] r_drain;
  logic                r_valid;
  logic                r_busy;
  logic                r_overrun;
  logic                r_hit;
  logic [IDWID-1:0]    r_best_id;
  logic [PRIOWID-1:0]  r_best_prio;
  logic [CNTWID-1:0]   r_count;

  level_edge_detect u_cc_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (bus.i_confirm_complete),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    w_load_drain = 1'b0;
    w_drain_dec  = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_COLLECT;
          w_clear     = 1'b1;
        end
      end
      ST_COLLECT: begin
        w_accept = bus.i_confirm_valid;
        if (w_rise) begin
          w_state_nxt  = ST_DRAIN;
          w_load_drain = 1'b1;
        end
      end
      ST_DRAIN: begin
        // A fall here is deliberately dropped: the window is already closed.
        w_accept = bus.i_confirm_valid;
        if (r_drain == '0) begin
          w_state_nxt = ST_RESULT;
        end else begin
          w_drain_dec = 1'b1;
        end
      end
      ST_RESULT: begin
        if (bus.i_result_ready) begin
          if (w_fall) begin
            w_state_nxt = ST_COLLECT;
            w_clear     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_fall) begin
          w_overrun = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_replace = ~r_hit |
                     prio_wins(PRIO_MAXW'(bus.i_confirm_priority), PRIO_MAXW'(r_best_prio));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain     <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_hit       <= 1'b0;
      r_best_id   <= '0;
      r_best_prio <= '0;
      r_count     <= '0;
    end else begin
      // Status flags are decoded from the next state so they line up with it.
      r_valid   <= (w_state_nxt == ST_RESULT);
      r_busy    <= (w_state_nxt == ST_COLLECT) || (w_state_nxt == ST_DRAIN);
      r_overrun <= w_overrun;

      if (w_load_drain) begin
        r_drain <= DRAIN_LOAD;
      end else if (w_drain_dec) begin
        r_drain <= r_drain - DRAIN_CW'(1);
      end

      if (w_clear) begin
        r_hit       <= 1'b0;
        r_best_id   <= '0;
        r_best_prio <= '0;
        r_count     <= '0;
      end else if (w_accept) begin
        if (w_replace) begin
          r_best_id   <= bus.i_confirm_ruleid;
          r_best_prio <= bus.i_confirm_priority;
        end
        r_hit <= 1'b1;
        if (r_count != '1) begin
          r_count <= r_count + CNTWID'(1);
        end
      end
    end
  end

  assign bus.o_result_valid    = r_valid;
  assign bus.o_result_hit      = r_hit;
  assign bus.o_result_ruleid   = r_best_id;
  assign bus.o_result_priority = r_best_prio;
  assign bus.o_match_count     = r_count;
  assign bus.o_busy            = r_busy;
  assign bus.o_overrun         = r_overrun;

endmodule
